// File: rtl/wn_axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO consecutive DW-bit beats into one wide word,
// lane 0 first, with per-lane keep; a tlast before the word is full flushes it early.
module wn_axis_upsizer #(
   parameter int DW    = 8,
   parameter int RATIO = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  input_tvalid,
   output logic                  input_tready,
   input  logic [DW-1:0]         input_tdata,
   input  logic [7:0]            input_tuser,
   input  logic                  input_tlast,
   output logic                  output_tvalid,
   input  logic                  output_tready,
   output logic [DW*RATIO-1:0]   output_tdata,
   output logic [RATIO-1:0]      output_tkeep,
   output logic [7:0]            output_tuser,
   output logic                  output_tlast
);

   localparam int CW = $clog2(RATIO);
   localparam int AW = DW * (RATIO - 1);

   logic [CW-1:0]       cnt;
   logic [AW-1:0]       acc;
   logic [RATIO-1:0]    kacc;
   logic [7:0]          uacc;
   logic                accept;
   logic                complete;
   logic                out_handshake;
   logic [DW*RATIO-1:0] acc_wide;
   logic [DW*RATIO-1:0] word_next;
   logic [RATIO-1:0]    keep_next;
   logic [7:0]          user_next;

   assign input_tready  = !reset && (!output_tvalid || output_tready);
   assign accept        = input_tvalid && input_tready;
   assign complete      = (cnt == CW'(RATIO - 1)) || input_tlast;
   assign out_handshake = output_tvalid && output_tready;
   assign user_next     = (cnt == '0) ? input_tuser : uacc;
   assign acc_wide      = {{DW{1'b0}}, acc};

   // Candidate word: stored lanes below cnt, current beat in lane cnt, zeros above.
   always_comb begin
      word_next = '0;
      keep_next = kacc;
      for (int i = 0; i < RATIO; i++) begin
         if (i < int'(cnt)) begin
            word_next[i*DW +: DW] = acc_wide[i*DW +: DW];
         end else if (i == int'(cnt)) begin
            word_next[i*DW +: DW] = input_tdata;
            keep_next[i]          = 1'b1;
         end
      end
   end

   // A completing beat reloads the output register even during a handshake,
   // so consecutive words leave without a bubble cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt           <= '0;
         acc           <= '0;
         kacc          <= '0;
         uacc          <= '0;
         output_tvalid <= 1'b0;
         output_tdata  <= '0;
         output_tkeep  <= '0;
         output_tuser  <= '0;
         output_tlast  <= 1'b0;
      end else begin
         if (accept && complete) begin
            output_tvalid <= 1'b1;
            output_tdata  <= word_next;
            output_tkeep  <= keep_next;
            output_tuser  <= user_next;
            output_tlast  <= input_tlast;
         end else if (out_handshake) begin
            output_tvalid <= 1'b0;
            output_tdata  <= '0;
            output_tkeep  <= '0;
            output_tuser  <= '0;
            output_tlast  <= 1'b0;
         end

         if (accept) begin
            if (cnt == '0) begin
               uacc <= input_tuser;
            end
            if (complete) begin
               cnt  <= '0;
               acc  <= '0;
               kacc <= '0;
            end else begin
               cnt  <= cnt + CW'(1);
               kacc <= keep_next;
               for (int i = 0; i < RATIO - 1; i++) begin
                  if (i == int'(cnt)) begin
                     acc[i*DW +: DW] <= input_tdata;
                  end
               end
            end
         end
      end
   end

endmodule
